// File: rtl/ikaopm_seq_pkg.sv
// Shared types and constants for the operator-pipeline slot sequencer.
package ikaopm_seq_pkg;

  localparam int unsigned SLOTS  = 32;
  localparam int unsigned SLOT_W = 5;

  typedef enum logic [1:0] {
    StSync  = 2'd0,
    StFlush = 2'd1,
    StRun   = 2'd2
  } seq_state_e;

endpackage

// File: rtl/ikaopm_seq_prescaler.sv
// Divides the emulation clock into active-low phi1 positive/negative edge enables.
// The freeze input gates all enables and parks the divider at 0.
module ikaopm_seq_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic freeze,
  output logic pcen_n,
  output logic ncen_n,
  output logic strobe
);

  localparam int unsigned PRE_W = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(DIV / 2 - 1);

  logic [PRE_W-1:0] pre_q, pre_d;

  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    if (freeze || pre_q == PRE_LAST) begin
      pre_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  // Enables are decoded straight from the register so they are glitch-free and one cycle wide.
  always_comb begin
    strobe = !freeze && (pre_q == PRE_LAST);
    pcen_n = !strobe;
    ncen_n = !(!freeze && (pre_q == PRE_HALF));
  end

endmodule

// File: rtl/ikaopm_slot_sequencer.sv
// Timing master for the 32-slot operator pipeline: phi1 enables, slot count, clear/flush/run FSM.
// Optional build macro IKAOPM_SEQ_FREEZE_EN adds the i_FREEZE input.
module ikaopm_slot_sequencer
  import ikaopm_seq_pkg::*;
#(
  parameter int unsigned DIV          = 4,
  parameter int unsigned FLUSH_ROUNDS = 1
) (
  input  logic              i_EMUCLK,
  input  logic              i_RST_n,
  input  logic              i_IC_n,
`ifdef IKAOPM_SEQ_FREEZE_EN
  input  logic              i_FREEZE,
`endif
  output logic              o_PCEN_n,
  output logic              o_NCEN_n,
  output logic [SLOT_W-1:0] o_SLOT,
  output logic              o_SLOT0,
  output logic              o_CNTRRST,
  output logic              o_WR,
  output logic              o_ZERO,
  output logic              o_BUSY
);

  localparam int unsigned RND_W = $clog2(FLUSH_ROUNDS) + 1;
  localparam logic [RND_W-1:0]  RND_LAST  = RND_W'(FLUSH_ROUNDS - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);

  logic strobe;
  logic freeze;

`ifdef IKAOPM_SEQ_FREEZE_EN
  assign freeze = i_FREEZE;
`else
  assign freeze = 1'b0;
`endif

  ikaopm_seq_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk    (i_EMUCLK),
    .rst_n  (i_RST_n),
    .freeze (freeze),
    .pcen_n (o_PCEN_n),
    .ncen_n (o_NCEN_n),
    .strobe (strobe)
  );

  seq_state_e        state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [RND_W-1:0]  rnd_q, rnd_d;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    rnd_d   = rnd_q;
    if (strobe) begin
      slot_d = slot_q + SLOT_W'(1);
      if (!i_IC_n) begin
        state_d = StSync;
        rnd_d   = '0;
      end else begin
        unique case (state_q)
          StSync:  state_d = StFlush;
          StFlush: begin
            if (slot_q == SLOT_LAST) begin
              if (rnd_q == RND_LAST) begin
                state_d = StRun;
                rnd_d   = '0;
              end else begin
                rnd_d = rnd_q + RND_W'(1);
              end
            end
          end
          StRun:   state_d = StRun;
          default: state_d = StSync;
        endcase
      end
      // Leaving SYNC restarts the slot together with the downstream write counter.
      if (state_d == StSync || state_q == StSync) begin
        slot_d = '0;
      end
    end
  end

  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q <= StSync;
      slot_q  <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    o_SLOT    = slot_q;
    o_SLOT0   = (slot_q == '0);
    o_CNTRRST = 1'b0;
    o_WR      = 1'b1;
    o_ZERO    = 1'b0;
    o_BUSY    = 1'b0;
    unique case (state_q)
      StSync: begin
        o_CNTRRST = 1'b1;
        o_WR      = 1'b0;
        o_ZERO    = 1'b1;
        o_BUSY    = 1'b1;
      end
      StFlush: begin
        o_ZERO = 1'b1;
        o_BUSY = 1'b1;
      end
      StRun:   ;
      default: begin
        o_CNTRRST = 1'b1;
        o_WR      = 1'b0;
        o_ZERO    = 1'b1;
        o_BUSY    = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/ikaopm_slot_sequencer.md
Name: ikaopm_slot_sequencer

Overview:
Timing master for the 32-slot operator pipeline. Divides i_EMUCLK into the phi1 positive/negative clock enables consumed by the counter, shift-register and BRAM shift-register primitives. Tracks the current slot (0..31). Sequences BRAM-SR counter reset and the zero-flush after initial clear, then hands over to normal run.

Parameters:
DIV, 4, i_EMUCLK cycles per phi1 period; even, >=2
FLUSH_ROUNDS, 1, full 32-slot passes of zero-writes after initial clear; >=1

Ports:
i_EMUCLK  in  1  emulation clock, sole clock
i_RST_n  in  1  asynchronous active-low reset
i_IC_n  in  1  chip initial clear, active-low; sampled only on PCEN strobes
o_PCEN_n  out  1  phi1 positive-edge enable, active-low, one i_EMUCLK wide
o_NCEN_n  out  1  phi1 negative-edge enable, active-low, one i_EMUCLK wide
o_SLOT  out  5  current slot number
o_SLOT0  out  1  high while o_SLOT==0
o_CNTRRST  out  1  to BRAM-SR i_CNTRRST
o_WR  out  1  to BRAM-SR i_WR
o_ZERO  out  1  datapath selects zero as SR input
o_BUSY  out  1  high until RUN reached

Behaviour:
- Clock and reset: one clock, i_EMUCLK. Reset is asynchronous and active-low on i_RST_n. All state is cleared asynchronously. Reset release is not synchronised inside the block.
- Reset values:
  - prescaler pre=0, state=SYNC, slot=0.
  - Outputs: o_PCEN_n=1, o_NCEN_n=1, o_SLOT=0, o_SLOT0=1, o_CNTRRST=1, o_WR=0, o_ZERO=1, o_BUSY=1.
- Prescaler:
  - pre counts 0..DIV-1 and wraps.
  - o_PCEN_n=0 exactly while pre==DIV-1.
  - o_NCEN_n=0 exactly while pre==DIV/2-1.
  - Both are decoded from the pre register, never asserted together, and each has a period of DIV.
  - The first NCEN strobe after reset release comes DIV/2 cycles after release; the first PCEN strobe comes DIV cycles after release.
- Strobe: the i_EMUCLK edge on which pre==DIV-1. All state and slot updates happen only on strobes.
- Slot counter: 5-bit, increments mod 32 on each strobe (31->0 wrap). Forced to 0 on any strobe where the next state is SYNC.
- FSM states and transitions (evaluated on strobes; i_IC_n low has priority in every state):
  - SYNC: o_CNTRRST=1, o_WR=0, o_ZERO=1, o_BUSY=1. i_IC_n=1 -> FLUSH with slot=0; otherwise stay.
  - FLUSH: o_CNTRRST=0, o_WR=1, o_ZERO=1, o_BUSY=1. Round counter rnd (width clog2(FLUSH_ROUNDS)+1) counts slot wraps. The strobe with slot==31 and rnd==FLUSH_ROUNDS-1 -> RUN. i_IC_n=0 -> SYNC with rnd=0.
  - RUN: o_CNTRRST=0, o_WR=1, o_ZERO=0, o_BUSY=0. i_IC_n=0 -> SYNC.
- Output timing: state-decoded outputs change one i_EMUCLK after the strobe edge. They are stable across the next full phi1 period, including the next PCEN/NCEN strobes.
- Alignment guarantee: the strobe leaving SYNC resets the downstream write counter to 0 while o_SLOT becomes 0. On every later strobe both advance together, so wrcntr==o_SLOT in FLUSH and RUN.
- FLUSH duration: exactly 32*FLUSH_ROUNDS strobes of o_WR=1 with o_ZERO=1.
- Boundary conditions:
  - i_IC_n pulse shorter than DIV and not covering a strobe: ignored.
  - i_IC_n low mid-FLUSH: the flush restarts from zero after release.
  - i_RST_n asserted mid-period: immediate return to reset values; no partial strobe is emitted.

Optional Feature:
IKAOPM_SEQ_FREEZE_EN
- With the macro: adds input i_FREEZE (1 bit). When i_FREEZE=1 and pre==DIV-1, the strobe is suppressed (o_PCEN_n stays 1) and pre holds at 0. While frozen, no enables are issued and the slot and FSM hold. On i_FREEZE=0, counting resumes from pre=0, and the first strobe follows after DIV cycles.
- Without the macro: the port is absent and the block behaves as if i_FREEZE=0.

Decomposition:
- Package ikaopm_seq_pkg: state encoding (SYNC=2'd0, FLUSH=2'd1, RUN=2'd2), SLOTS=32, SLOT_W=5.
- Sub-module ikaopm_seq_prescaler: pre counter, PCEN/NCEN decode, strobe output, freeze gating.
- The FSM, slot counter and round counter stay in the top module.

Test Plan:
- Reset release, DIV=4, i_IC_n=1, FLUSH_ROUNDS=1 -> o_NCEN_n low in cycle 2, o_PCEN_n low in cycle 4, period 4; FLUSH entered on the 1st strobe; o_BUSY falls after strobe 33; o_ZERO falls with it.
- RUN, 64 strobes -> o_SLOT sequence 0..31,0..31; o_SLOT0 high exactly 2 phi1 periods; o_WR constantly 1.
- i_IC_n low for 3 phi1 periods during RUN at slot 17 -> SYNC on next strobe, o_SLOT=0, o_CNTRRST=1, o_WR=0; then a 32-strobe FLUSH, then RUN.
- i_IC_n low for 2 i_EMUCLK cycles, not covering a strobe -> no state change, o_SLOT continues.
- i_RST_n asserted at pre=1 in FLUSH slot 9 -> all outputs at reset values asynchronously, before the next i_EMUCLK edge.
- FREEZE build, i_FREEZE=1 for 20 cycles at slot 5 -> no PCEN/NCEN strobes; o_SLOT stays 5; after release, first o_PCEN_n low 4 cycles later and o_SLOT=6.
